// File: rtl/tftp_pkg.sv
// Shared TFTP decode constants: opcodes, event codes, FSM states and default offsets.
package tftp_pkg;

  localparam logic [15:0] OP_RRQ  = 16'd1;
  localparam logic [15:0] OP_WRQ  = 16'd2;
  localparam logic [15:0] OP_DATA = 16'd3;
  localparam logic [15:0] OP_ACK  = 16'd4;
  localparam logic [15:0] OP_ERR  = 16'd5;

  localparam logic [15:0] DEF_SERVER_PORT = 16'd69;
  localparam int          DEF_HDR_OFFSET  = 42;
  localparam int          DEF_BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    EVT_NONE = 3'd0,
    EVT_NEW  = 3'd1,
    EVT_ACK  = 3'd2,
    EVT_DUP  = 3'd3,
    EVT_ERR  = 3'd4,
    EVT_FULL = 3'd5,
    EVT_REJ  = 3'd6
  } evt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_LOOKUP,
    ST_COMMIT,
    ST_EMIT
  } state_e;

  function automatic int sid_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tftp_session_table.sv
// Per-slot client port / next block / busy storage with a sequential scan read port.
// A close on the same slot as a write in the same cycle leaves the slot free.
module tftp_session_table
  import tftp_pkg::*;
#(
  parameter int NUM_SESSIONS = 4,
  parameter int SID_W        = 2
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clr,
  input  logic                    scan_inc,
  input  logic                    wr_en,
  input  logic [SID_W-1:0]        wr_sid,
  input  logic [15:0]             wr_port,
  input  logic [15:0]             wr_next,
  input  logic                    wr_busy,
  input  logic                    close_req,
  input  logic [SID_W-1:0]        close_sid,
  output logic [SID_W-1:0]        scan_idx,
  output logic [15:0]             rd_port,
  output logic [15:0]             rd_next,
  output logic                    rd_busy,
  output logic [NUM_SESSIONS-1:0] sess_busy
);

  logic [NUM_SESSIONS-1:0][15:0] port_q;
  logic [NUM_SESSIONS-1:0][15:0] nxt_q;
  logic [NUM_SESSIONS-1:0]       busy_q;

  logic wr_ok, close_ok, rd_ok;
  assign wr_ok    = 32'(wr_sid)    < NUM_SESSIONS;
  assign close_ok = 32'(close_sid) < NUM_SESSIONS;
  assign rd_ok    = 32'(scan_idx)  < NUM_SESSIONS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q   <= '0;
      nxt_q    <= '0;
      busy_q   <= '0;
      scan_idx <= '0;
    end else begin
      if (scan_clr)      scan_idx <= '0;
      else if (scan_inc) scan_idx <= scan_idx + SID_W'(1);
      if (wr_en && wr_ok) begin
        port_q[wr_sid] <= wr_port;
        nxt_q[wr_sid]  <= wr_next;
        busy_q[wr_sid] <= wr_busy;
      end
      // Later assignment gives the close priority over a same-slot write.
      if (close_req && close_ok) busy_q[close_sid] <= 1'b0;
    end
  end

  assign rd_port   = rd_ok ? port_q[scan_idx] : 16'd0;
  assign rd_next   = rd_ok ? nxt_q[scan_idx]  : 16'd0;
  assign rd_busy   = rd_ok ? busy_q[scan_idx] : 1'b0;
  assign sess_busy = busy_q;

endmodule

// File: rtl/tftp_rx_session_decode.sv
// TFTP receive header decoder tracking NUM_SESSIONS read sessions keyed by client port;
// emits one event per accepted frame, NUM_SESSIONS+2 cycles after frame_end.
module tftp_rx_session_decode
  import tftp_pkg::*;
#(
  parameter int          NUM_SESSIONS = 4,
  parameter logic [15:0] SERVER_PORT  = DEF_SERVER_PORT,
  parameter int          HDR_OFFSET   = DEF_HDR_OFFSET,
  parameter int          BLOCK_BYTES  = DEF_BLOCK_BYTES,
  localparam int         SID_W        = sid_width(NUM_SESSIONS),
  localparam int         LEN_W        = $clog2(BLOCK_BYTES + 1)
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              cnt,
  input  logic [7:0]              eth_data,
  input  logic [15:0]             udp_dst,
  input  logic                    frame_end,
  input  logic                    frame_ok,
  input  logic                    close_req,
  input  logic [SID_W-1:0]        close_sid,
  output logic                    valid,
  output logic [2:0]              evt_type,
  output logic [SID_W-1:0]        evt_sid,
  output logic [15:0]             tid,
  output logic [15:0]             next_block_no,
  output logic [LEN_W-1:0]        length,
  output logic [NUM_SESSIONS-1:0] sess_busy
);

  localparam logic [7:0]       IDX_SRC_HI = 8'(HDR_OFFSET - 8);
  localparam logic [7:0]       IDX_SRC_LO = 8'(HDR_OFFSET - 7);
  localparam logic [7:0]       IDX_OPC_HI = 8'(HDR_OFFSET);
  localparam logic [7:0]       IDX_OPC_LO = 8'(HDR_OFFSET + 1);
  localparam logic [7:0]       IDX_BLK_HI = 8'(HDR_OFFSET + 2);
  localparam logic [7:0]       IDX_BLK_LO = 8'(HDR_OFFSET + 3);
  localparam logic [SID_W-1:0] LAST_SID   = SID_W'(NUM_SESSIONS - 1);

  logic [15:0] src, opc, blk;
  logic        got_all;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src     <= '0;
      opc     <= '0;
      blk     <= '0;
      got_all <= 1'b0;
    end else begin
      if (cnt == 8'd0)       got_all   <= 1'b0;
      if (cnt == IDX_SRC_HI) src[15:8] <= eth_data;
      if (cnt == IDX_SRC_LO) src[7:0]  <= eth_data;
      if (cnt == IDX_OPC_HI) opc[15:8] <= eth_data;
      if (cnt == IDX_OPC_LO) opc[7:0]  <= eth_data;
      if (cnt == IDX_BLK_HI) blk[15:8] <= eth_data;
      if (cnt == IDX_BLK_LO) begin
        blk[7:0] <= eth_data;
        got_all  <= 1'b1;
      end
    end
  end

  state_e            state;
  logic              dst_srv;
  logic              m_found, f_found;
  logic [SID_W-1:0]  m_sid, f_sid;
  logic [15:0]       m_next;
  logic              p_fire;
  evt_e              p_type;
  logic [SID_W-1:0]  p_sid;
  logic [15:0]       p_tid, p_next;

  logic [SID_W-1:0]  scan_idx;
  logic [15:0]       rd_port, rd_next;
  logic              rd_busy;

  logic              wr_en, wr_busy;
  logic [SID_W-1:0]  wr_sid;
  logic [15:0]       wr_port, wr_next;
  logic              d_fire;
  evt_e              d_type;
  logic [SID_W-1:0]  d_sid;
  logic [15:0]       d_next;
  logic              clash;

  tftp_session_table #(
    .NUM_SESSIONS (NUM_SESSIONS),
    .SID_W        (SID_W)
  ) u_tab (
    .clk       (clk),
    .reset     (reset),
    .scan_clr  (state != ST_LOOKUP),
    .scan_inc  (state == ST_LOOKUP),
    .wr_en     (wr_en),
    .wr_sid    (wr_sid),
    .wr_port   (wr_port),
    .wr_next   (wr_next),
    .wr_busy   (wr_busy),
    .close_req (close_req),
    .close_sid (close_sid),
    .scan_idx  (scan_idx),
    .rd_port   (rd_port),
    .rd_next   (rd_next),
    .rd_busy   (rd_busy),
    .sess_busy (sess_busy)
  );

  // Event decision from the scan results; only acted on in COMMIT.
  always_comb begin
    wr_en   = 1'b0;
    wr_sid  = m_sid;
    wr_port = src;
    wr_next = 16'd1;
    wr_busy = 1'b1;
    d_fire  = 1'b0;
    d_type  = EVT_NONE;
    d_sid   = m_sid;
    d_next  = m_next;
    if (opc == OP_RRQ && dst_srv) begin
      d_fire = 1'b1;
      d_type = EVT_NEW;
      d_next = 16'd1;
      if (m_found) begin
        wr_en = 1'b1;
      end else if (f_found) begin
        wr_en  = 1'b1;
        wr_sid = f_sid;
        d_sid  = f_sid;
      end else begin
        d_type = EVT_FULL;
        d_sid  = '0;
        d_next = 16'd0;
      end
    end else if (opc == OP_WRQ && dst_srv) begin
      d_fire = 1'b1;
      d_type = EVT_REJ;
      d_sid  = '0;
      d_next = 16'd0;
    end else if (opc == OP_ACK && !dst_srv && m_found) begin
      if (blk == m_next) begin
        wr_en   = 1'b1;
        wr_next = blk + 16'd1;
        d_fire  = 1'b1;
        d_type  = EVT_ACK;
        d_next  = blk + 16'd1;
      end else if (blk == m_next - 16'd1) begin
        d_fire = 1'b1;
        d_type = EVT_DUP;
      end
    end else if (opc == OP_ERR && m_found) begin
      wr_en   = 1'b1;
      wr_busy = 1'b0;
      wr_next = m_next;
      d_fire  = 1'b1;
      d_type  = EVT_ERR;
    end
    if (state != ST_COMMIT) wr_en = 1'b0;
  end

  assign clash  = wr_en && close_req && (close_sid == wr_sid);
  assign length = LEN_W'(BLOCK_BYTES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      dst_srv       <= 1'b0;
      m_found       <= 1'b0;
      f_found       <= 1'b0;
      m_sid         <= '0;
      f_sid         <= '0;
      m_next        <= '0;
      p_fire        <= 1'b0;
      p_type        <= EVT_NONE;
      p_sid         <= '0;
      p_tid         <= '0;
      p_next        <= '0;
      valid         <= 1'b0;
      evt_type      <= '0;
      evt_sid       <= '0;
      tid           <= '0;
      next_block_no <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: if (cnt == 8'd0) state <= ST_COLLECT;
        ST_COLLECT: begin
          if (frame_end) begin
            if (frame_ok && got_all) begin
              state   <= ST_LOOKUP;
              dst_srv <= (udp_dst == SERVER_PORT);
              m_found <= 1'b0;
              f_found <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_LOOKUP: begin
          if (rd_busy && rd_port == src) begin
            m_found <= 1'b1;
            m_sid   <= scan_idx;
            m_next  <= rd_next;
          end
          if (!rd_busy && !f_found) begin
            f_found <= 1'b1;
            f_sid   <= scan_idx;
          end
          if (scan_idx == LAST_SID) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          p_fire <= d_fire && !clash;
          p_type <= d_type;
          p_sid  <= d_sid;
          p_tid  <= src;
          p_next <= d_next;
          state  <= ST_EMIT;
        end
        ST_EMIT: begin
          valid <= p_fire;
          if (p_fire) begin
            evt_type      <= p_type;
            evt_sid       <= p_sid;
            tid           <= p_tid;
            next_block_no <= p_next;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tftp_rx_session_decode.sv
// Randomized scoreboard bench for tftp_rx_session_decode against a slot-table reference model.
module tb_tftp_rx_session_decode;
  import tftp_pkg::*;

  localparam int N     = 4;
  localparam int SID_W = 2;
  localparam int LEN_W = 10;
  localparam int HDR   = 42;
  localparam int GAP   = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       cnt, eth_data;
  logic [15:0]      udp_dst;
  logic             frame_end, frame_ok, close_req;
  logic [SID_W-1:0] close_sid;
  logic             valid;
  logic [2:0]       evt_type;
  logic [SID_W-1:0] evt_sid;
  logic [15:0]      tid, next_block_no;
  logic [LEN_W-1:0] length;
  logic [N-1:0]     sess_busy;

  tftp_rx_session_decode #(
    .NUM_SESSIONS (N),
    .SERVER_PORT  (16'd69),
    .HDR_OFFSET   (HDR),
    .BLOCK_BYTES  (512)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cnt           (cnt),
    .eth_data      (eth_data),
    .udp_dst       (udp_dst),
    .frame_end     (frame_end),
    .frame_ok      (frame_ok),
    .close_req     (close_req),
    .close_sid     (close_sid),
    .valid         (valid),
    .evt_type      (evt_type),
    .evt_sid       (evt_sid),
    .tid           (tid),
    .next_block_no (next_block_no),
    .length        (length),
    .sess_busy     (sess_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]  typ;
    int          sid;
    logic [15:0] tid;
    logic [15:0] nxt;
    int          due;
  } exp_t;
  exp_t q[$];

  // Reference session table
  logic        m_busy [N];
  logic [15:0] m_port [N];
  logic [15:0] m_next [N];

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0; m_port[i] = '0; m_next[i] = '0;
    end
  endfunction

  function automatic logic [N-1:0] model_busy();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int find_port(input logic [15:0] p);
    for (int i = 0; i < N; i++) if (m_busy[i] && m_port[i] == p) return i;
    return -1;
  endfunction

  function automatic bit model(input logic [15:0] opc, input logic [15:0] src,
                               input logic [15:0] blk, input logic [15:0] dst,
                               output exp_t e);
    int mi, fi, s;
    bit srv;
    srv = (dst == 16'd69);
    mi  = find_port(src);
    fi  = -1;
    for (int i = 0; i < N; i++) if (!m_busy[i] && fi < 0) fi = i;
    e.tid = src; e.due = 0; e.sid = 0; e.nxt = 0; e.typ = EVT_NONE;
    if (opc == 16'd1 && srv) begin
      if (mi < 0 && fi < 0) begin
        e.typ = EVT_FULL;
        return 1'b1;
      end
      s = (mi >= 0) ? mi : fi;
      m_busy[s] = 1'b1; m_port[s] = src; m_next[s] = 16'd1;
      e.typ = EVT_NEW; e.sid = s; e.nxt = 16'd1;
      return 1'b1;
    end
    if (opc == 16'd2 && srv) begin
      e.typ = EVT_REJ;
      return 1'b1;
    end
    if (opc == 16'd4 && !srv && mi >= 0) begin
      e.sid = mi;
      if (blk == m_next[mi]) begin
        m_next[mi] = 16'(blk + 16'd1);
        e.typ = EVT_ACK; e.nxt = m_next[mi];
        return 1'b1;
      end
      if (blk == 16'(m_next[mi] - 16'd1)) begin
        e.typ = EVT_DUP; e.nxt = m_next[mi];
        return 1'b1;
      end
      return 1'b0;
    end
    if (opc == 16'd5 && mi >= 0) begin
      m_busy[mi] = 1'b0;
      e.typ = EVT_ERR; e.sid = mi; e.nxt = m_next[mi];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes valid
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (q.size() > 0 && cyc > q[0].due) begin
        total++; bad++;
        $display("FAIL missed_event: got=none want=type %0d at cyc %0d", q[0].typ, q[0].due);
        void'(q.pop_front());
      end
      if (valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: got=type %0d sid %0d want=none (cyc %0d)",
                   evt_type, evt_sid, cyc);
        end else begin
          e = q.pop_front();
          chk("latency",  cyc, e.due);
          chk("evt_type", evt_type, e.typ);
          chk("evt_sid",  evt_sid, e.sid);
          chk("tid",      tid, e.tid);
          chk("next_blk", next_block_no, e.nxt);
          chk("length",   length, 512);
        end
      end
    end
  end

  task automatic send(input logic [15:0] opc, input logic [15:0] src, input logic [15:0] blk,
                      input logic [15:0] dst, input bit ok, input int len);
    logic [7:0] b [64];
    exp_t e;
    for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
    b[HDR-8] = src[15:8]; b[HDR-7] = src[7:0];
    b[HDR]   = opc[15:8]; b[HDR+1] = opc[7:0];
    b[HDR+2] = blk[15:8]; b[HDR+3] = blk[7:0];
    udp_dst = dst;
    for (int c = 0; c < len; c++) begin
      cnt = 8'(c); eth_data = b[c];
      @(posedge clk); #1;
    end
    frame_end = 1'b1; frame_ok = ok;
    if (ok && len >= HDR + 4 && model(opc, src, blk, dst, e)) begin
      e.due = cyc + N + 3;
      q.push_back(e);
    end
    @(posedge clk); #1;
    frame_end = 1'b0; frame_ok = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    chk("sess_busy", sess_busy, model_busy());
  endtask

  task automatic close(input int s);
    close_req = 1'b1; close_sid = SID_W'(s);
    @(posedge clk); #1;
    close_req = 1'b0;
    m_busy[s] = 1'b0;
    chk("sess_busy_close", sess_busy, model_busy());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},    valid, 0);
    chk({tag, "_evt_type"}, evt_type, 0);
    chk({tag, "_evt_sid"},  evt_sid, 0);
    chk({tag, "_tid"},      tid, 0);
    chk({tag, "_next"},     next_block_no, 0);
    chk({tag, "_length"},   length, 512);
    chk({tag, "_busy"},     sess_busy, 0);
  endtask

  initial begin
    logic [N-1:0][15:0] fv;
    int r, s;
    logic [15:0] p, op, bk, dst;
    reset = 1'b1; cnt = 8'd63; eth_data = '0; udp_dst = '0;
    frame_end = 1'b0; frame_ok = 1'b0; close_req = 1'b0; close_sid = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed walk through the session lifecycle
    send(16'd1, 16'h0400, 16'd0, 16'h0045, 1'b1, 64);
    send(16'd4, 16'h0400, 16'd1, 16'h0400, 1'b1, 64);
    send(16'd4, 16'h0400, 16'd1, 16'h0400, 1'b1, 64);
    send(16'd4, 16'h0400, 16'd7, 16'h0400, 1'b1, 64);
    for (int i = 0; i < 5; i++) send(16'd1, 16'(16'h0400 + i), 16'd0, 16'h0045, 1'b1, 64);
    close(2);
    send(16'd1, 16'h0405, 16'd0, 16'h0045, 1'b1, 64);

    // Push slot 0 to the wrap point
    for (int i = 0; i < N; i++) fv[i] = m_next[i];
    fv[0] = 16'hFFFF;
    force dut.u_tab.nxt_q = fv;
    @(posedge clk); #1;
    release dut.u_tab.nxt_q;
    m_next[0] = 16'hFFFF;
    send(16'd4, 16'h0400, 16'hFFFF, 16'h0400, 1'b1, 64);
    send(16'd5, 16'h0400, 16'd3, 16'h0400, 1'b1, 64);
    chk("err_frees_slot0", sess_busy[0], 0);

    send(16'd2, 16'h0500, 16'd0, 16'h0045, 1'b1, 64);
    send(16'd1, 16'h0501, 16'd0, 16'h0045, 1'b1, 45);
    send(16'd1, 16'h0502, 16'd0, 16'h0045, 1'b0, 64);
    send(16'd4, 16'h0401, 16'd1, 16'h0045, 1'b1, 64);

    // Reset in the middle of an ACK frame
    udp_dst = 16'h0401;
    for (int c = 0; c < 64; c++) begin
      cnt = 8'(c); eth_data = 8'($urandom);
      if (c == HDR-8) eth_data = 8'h04;
      if (c == HDR-7) eth_data = 8'h01;
      if (c == 40) reset = 1'b1;
      if (c == 42) begin
        chk_reset_outputs("midrst");
        reset = 1'b0;
        model_clear();
      end
      @(posedge clk); #1;
    end
    frame_end = 1'b1; frame_ok = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0; frame_ok = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    chk("post_rst_busy", sess_busy, 0);
    send(16'd1, 16'h0400, 16'd0, 16'h0045, 1'b1, 64);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      r   = $urandom_range(0, 99);
      p   = 16'(16'h0400 + $urandom_range(0, 5));
      dst = p;
      bk  = 16'($urandom);
      if (r < 30) begin
        op = 16'd1; dst = ($urandom_range(0, 9) == 0) ? p : 16'h0045;
      end else if (r < 65) begin
        op = 16'd4;
        s = find_port(p);
        if (s >= 0) begin
          case ($urandom_range(0, 2))
            0: bk = m_next[s];
            1: bk = 16'(m_next[s] - 16'd1);
            default: ;
          endcase
        end
        if ($urandom_range(0, 9) == 0) dst = 16'h0045;
      end else if (r < 75) begin
        op = 16'd5;
      end else if (r < 85) begin
        op = 16'd2; dst = ($urandom_range(0, 4) == 0) ? p : 16'h0045;
      end else begin
        op = 16'($urandom_range(0, 7));
      end
      send(op, p, bk, dst, $urandom_range(0, 9) != 0, 64);
      if ($urandom_range(0, 6) == 0) close($urandom_range(0, N-1));
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tftp_rx_session_decode.md
# tftp_rx_session_decode

Parametrised successor to the single-session TFTP receive decoder. It parses the TFTP header from the byte-indexed Ethernet receive stream and tracks up to NUM_SESSIONS concurrent read sessions, keyed by client UDP port. For every accepted frame it emits one event (new, ack, duplicate, error, full, reject) to the TFTP transmit side. It sits between the UDP/IP receive filter (`cnt`, `eth_data`, `udp_dst`) and the data-block transmitter.

## Interface
- NUM_SESSIONS, 4: session slots (1..32); SID_W = max(1, $clog2(NUM_SESSIONS)).
- SERVER_PORT, 16'd69: well-known port; RRQ/WRQ accepted only here.
- HDR_OFFSET, 42: byte index of the TFTP opcode MSB; client source port lives at HDR_OFFSET-8 and HDR_OFFSET-7.
- BLOCK_BYTES, 512: data block size reported on `length`; LEN_W = $clog2(BLOCK_BYTES+1).
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cnt  in  8  byte index within the current frame; 0 marks frame start
- eth_data  in  8  receive byte at index `cnt`
- udp_dst  in  16  UDP destination port of the current frame, stable by frame_end
- frame_end  in  1  one-cycle strobe after the last byte
- frame_ok  in  1  upstream CRC/IP/UDP checks passed; sampled with frame_end
- close_req  in  1  transmitter frees a slot (transfer done)
- close_sid  in  SID_W  slot to free
- valid  out  1  one-cycle event strobe
- evt_type  out  3  EVT_NEW/ACK/DUP/ERR/FULL/REJ
- evt_sid  out  SID_W  session slot of the event
- tid  out  16  client port of the event
- next_block_no  out  16  next block to transmit for that session
- length  out  LEN_W  BLOCK_BYTES
- sess_busy  out  NUM_SESSIONS  per-slot occupied flags

## Operation
- Capture: at cnt == HDR_OFFSET-8/-7 latch source port (MSB first); at HDR_OFFSET/+1 opcode; at HDR_OFFSET+2/+3 block/error code. `got_all` is set at HDR_OFFSET+3; cnt == 0 clears it and restarts capture.
- FSM: IDLE -> COLLECT (cnt == 0) -> LOOKUP (frame_end, frame_ok, got_all) -> COMMIT -> EMIT -> IDLE. frame_end with !frame_ok or !got_all returns to IDLE with no event.
- LOOKUP scans slots 0..NUM_SESSIONS-1, one per cycle, recording the matching slot (busy && port == src) and the lowest free slot.
- Opcode 1 (RRQ), udp_dst == SERVER_PORT: matching slot -> restart with next_block=1; else allocate lowest free slot with next_block=1; either gives EVT_NEW. No free slot -> EVT_FULL, evt_sid=0.
- Opcode 2 (WRQ), udp_dst == SERVER_PORT: EVT_REJ; no table change.
- Opcode 4 (ACK), udp_dst != SERVER_PORT, matching slot: blk == next_block -> next_block = blk+1 mod 2^16 (0xFFFF -> 0x0000), EVT_ACK; blk == next_block-1 mod 2^16 -> EVT_DUP, unchanged; any other blk -> no event.
- Opcode 5 (ERROR), matching slot: free slot, EVT_ERR, next_block_no reports the stored value.
- No matching slot for ACK/ERROR, other opcodes, or port rule violated: no event.
- close_req clears sess_busy[close_sid] in the next cycle, in any state. When the same slot is written in COMMIT that cycle, close wins and that frame's event is suppressed.

## Timing
- Reset: valid=0, evt_type=0, evt_sid=0, tid=0, next_block_no=0, length=BLOCK_BYTES, sess_busy=0, FSM=IDLE. Reset mid-frame or mid-scan discards the frame.
- valid rises exactly NUM_SESSIONS+2 cycles after frame_end and lasts one cycle. Outputs other than valid hold until the next event.
- Minimum frame spacing (64 bytes) exceeds the latency. frame_end arriving outside COLLECT is ignored.

## Structure
- Package tftp_pkg: opcode constants, EVT_* codes, default offsets, SERVER_PORT default.
- Sub-module tftp_session_table: port/next_block/busy storage, scan index, write and close port with the close-priority rule.

## Test plan
- RRQ, src 0x0400, udp_dst 0x45, NUM_SESSIONS=4 -> valid after 6 cycles, EVT_NEW, sid 0, tid 0x400, next_block_no 1, length 0x200.
- Then ACK blk 1 from 0x0400, udp_dst 0x400 -> EVT_ACK, next_block_no 2. Repeat ACK blk 1 -> EVT_DUP, next 2. ACK blk 7 -> no valid.
- Five RRQs from ports 0x400..0x404 -> sids 0..3 EVT_NEW, fifth EVT_FULL. close_req sid 2, then a sixth RRQ -> EVT_NEW sid 2.
- Force slot next_block to 0xFFFF, ACK 0xFFFF -> next_block_no 0x0000. ERROR from that port -> EVT_ERR, sess_busy bit clear.
- WRQ to 0x45 -> EVT_REJ. Frame truncated at cnt 44, or frame_ok=0 -> no valid.
- Assert reset at cnt 40 of an ACK frame -> all outputs at reset values, sess_busy 0, next frame decodes normally.
